// File: rtl/mips_pkg.sv
// Shared fetch-stage types: FSM state, FIFO entry layout and default depth.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

  localparam int ENTRY_W              = 65;
  localparam int IFETCH_DEPTH_DEFAULT = 2;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: DEPTH entries (power of two), push/pop/flush, head from registers.
module ifetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = IFETCH_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [ENTRY_W-1:0]          push_data_i,
  input  logic                        pop_i,
  output logic                        head_valid_o,
  output logic [ENTRY_W-1:0]          head_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               pop_ok_s, wr_ok_s;

  // Pointer/count/storage update; flush wins over any same-cycle push or pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop_ok_s = pop_i & (count_q != {CW{1'b0}});
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    wr_ok_s  = push_i & ((count_q < CW'(DEPTH)) | pop_ok_s);
    if (flush_i) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{(CW-1){1'b0}}, wr_ok_s} - {{(CW-1){1'b0}}, pop_ok_s};
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ENTRY_W{1'b0}};
      end
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid_o = (count_q != {CW{1'b0}});
  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: req/gnt/rvalid memory handshake, PC back-pressure, flush of stale fetches.
// Optional misaligned-PC trap entries are enabled by defining IFETCH_MISALIGN_TRAP_EN.
module ifetch
  import mips_pkg::*;
#(
  parameter int DEPTH = IFETCH_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        R,
  input  logic [31:0] pc_i,
  output logic        pc_hold_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic        if_exc_o,
  input  logic        if_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [CW-1:0]      count_s;
  logic               has_room_s, misalign_s, granted_s, trap_push_s, push_s, pop_s;
  logic               head_valid_s;
  logic [ENTRY_W-1:0] head_raw_s;
  fetch_entry_t       push_entry_s, head_s;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign misalign_s = (pc_i[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  assign has_room_s = (count_s < CW'(DEPTH));

  // State and request-PC registers.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q  <= IDLE;
      req_pc_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next-state logic; flush redirects any accepted or pending fetch into DISCARD.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (granted_s) begin
          req_pc_d = pc_i;
          state_d  = flush_i ? DISCARD : WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_d = REQ;
        end else if (flush_i) begin
          state_d = DISCARD;
        end else begin
          state_d = WAIT;
        end
      end
      DISCARD: begin
        if (imem_rvalid_i) begin
          state_d = REQ;
        end else begin
          state_d = DISCARD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs and FIFO push selection.
  always_comb begin
    imem_req_o  = 1'b0;
    trap_push_s = 1'b0;
    if (state_q == REQ) begin
      imem_req_o  = has_room_s & ~misalign_s;
      trap_push_s = has_room_s & misalign_s;
    end else begin
      imem_req_o  = 1'b0;
      trap_push_s = 1'b0;
    end
    granted_s   = imem_req_o & imem_gnt_i;
    pc_hold_o   = ~(granted_s | trap_push_s);
    imem_addr_o = word_align(pc_i);
    push_s      = trap_push_s | ((state_q == WAIT) & imem_rvalid_i & ~flush_i);
    if (trap_push_s) begin
      push_entry_s = '{pc: pc_i, instr: 32'h0000_0000, exc: 1'b1};
    end else begin
      push_entry_s = '{pc: req_pc_q, instr: imem_rdata_i, exc: 1'b0};
    end
  end

  assign pop_s = head_valid_s & if_ready_i;

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (R),
    .flush_i      (flush_i),
    .push_i       (push_s),
    .push_data_i  (push_entry_s),
    .pop_i        (pop_s),
    .head_valid_o (head_valid_s),
    .head_o       (head_raw_s),
    .count_o      (count_s)
  );

  assign head_s     = fetch_entry_t'(head_raw_s);
  assign if_valid_o = head_valid_s;
  assign if_instr_o = head_s.instr;
  assign if_pc_o    = head_s.pc;
  assign if_exc_o   = head_s.exc;

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch; inputs driven and outputs sampled in the low clock phase.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        R;
  logic [31:0] pc_i;
  logic        pc_hold_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        if_exc_o;
  logic        if_ready_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk           (clk),
    .R             (R),
    .pc_i          (pc_i),
    .pc_hold_o     (pc_hold_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_exc_o      (if_exc_o),
    .if_ready_i    (if_ready_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One fetch from REQ: gnt after gdly idle cycles, rvalid rdly cycles after gnt.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int gdly, input int rdly);
    pc_i = pc;
    for (int i = 0; i < gdly; i++) begin
      #1;
      check_eq("gnt_wait_req", {31'd0, imem_req_o}, 32'd1);
      check_eq("gnt_wait_addr", imem_addr_o, {pc[31:2], 2'b00});
      check_eq("gnt_wait_hold", {31'd0, pc_hold_o}, 32'd1);
      step();
    end
    imem_gnt_i = 1'b1;
    #1 check_eq("gnt_hold", {31'd0, pc_hold_o}, 32'd0);
    step();
    imem_gnt_i = 1'b0;
    pc_i = pc + 32'd4;
    for (int i = 1; i < rdly; i++) begin
      #1;
      check_eq("rv_wait_hold", {31'd0, pc_hold_o}, 32'd1);
      check_eq("rv_wait_req", {31'd0, imem_req_o}, 32'd0);
      step();
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    step();
    imem_rvalid_i = 1'b0;
  endtask

  initial begin
    R             = 1'b0;
    pc_i          = 32'h0000_0123;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    if_ready_i    = 1'b1;

    // Reset then steady fetch
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("rst_hold", {31'd0, pc_hold_o}, 32'd1);
    check_eq("rst_addr", imem_addr_o, 32'h0000_0120);
    check_eq("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check_eq("rst_instr", if_instr_o, 32'h0);
    check_eq("rst_pc", if_pc_o, 32'h0);
    check_eq("rst_exc", {31'd0, if_exc_o}, 32'd0);
    pc_i = 32'h0;
    R    = 1'b1;
    step();
    #1 check_eq("idle_to_req", {31'd0, imem_req_o}, 32'd1);
    fetch(32'h0, 32'h2008_0005, 0, 1);
    #1;
    check_eq("t1_valid", {31'd0, if_valid_o}, 32'd1);
    check_eq("t1_pc", if_pc_o, 32'h0);
    check_eq("t1_instr", if_instr_o, 32'h2008_0005);
    check_eq("t1_next_req", {31'd0, imem_req_o}, 32'd1);
    step();
    #1 check_eq("t1_popped", {31'd0, if_valid_o}, 32'd0);

    // FIFO full backpressure
    if_ready_i = 1'b0;
    fetch(32'h0, 32'hAAAA_0000, 0, 1);
    fetch(32'h4, 32'hAAAA_0004, 0, 1);
    #1;
    check_eq("full_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("full_hold", {31'd0, pc_hold_o}, 32'd1);
    check_eq("full_head", if_pc_o, 32'h0);
    step();
    #1;
    check_eq("full_req2", {31'd0, imem_req_o}, 32'd0);
    check_eq("full_hold2", {31'd0, pc_hold_o}, 32'd1);
    if_ready_i = 1'b1;
    step();
    if_ready_i = 1'b0;
    #1;
    check_eq("pop_head_pc", if_pc_o, 32'h4);
    check_eq("pop_head_instr", if_instr_o, 32'hAAAA_0004);
    check_eq("pop_req", {31'd0, imem_req_o}, 32'd1);
    check_eq("pop_addr", imem_addr_o, 32'h8);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    check_eq("flush_req_empty", {31'd0, if_valid_o}, 32'd0);
    check_eq("flush_req_stays", {31'd0, imem_req_o}, 32'd1);

    // Flush during WAIT
    if_ready_i = 1'b1;
    pc_i       = 32'h10;
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    flush_i    = 1'b1;
    pc_i       = 32'h40;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 check_eq("discard_req", {31'd0, imem_req_o}, 32'd0);
      step();
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    step();
    imem_rvalid_i = 1'b0;
    #1;
    check_eq("discard_nopush", {31'd0, if_valid_o}, 32'd0);
    check_eq("redirect_req", {31'd0, imem_req_o}, 32'd1);
    check_eq("redirect_addr", imem_addr_o, 32'h40);

    // Flush coincident with gnt
    imem_gnt_i = 1'b1;
    flush_i    = 1'b1;
    #1 check_eq("flush_gnt_hold", {31'd0, pc_hold_o}, 32'd0);
    step();
    imem_gnt_i = 1'b0;
    flush_i    = 1'b0;
    #1;
    check_eq("flush_gnt_discard", {31'd0, imem_req_o}, 32'd0);
    check_eq("flush_gnt_empty", {31'd0, if_valid_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    step();
    imem_rvalid_i = 1'b0;
    #1;
    check_eq("flush_gnt_back_req", {31'd0, imem_req_o}, 32'd1);
    check_eq("flush_gnt_nopush", {31'd0, if_valid_o}, 32'd0);

    // Flush coincident with rvalid
    if_ready_i = 1'b0;
    fetch(32'h40, 32'h1111_1111, 0, 1);
    #1 check_eq("pre_flush_valid", {31'd0, if_valid_o}, 32'd1);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h2222_2222;
    flush_i       = 1'b1;
    step();
    imem_rvalid_i = 1'b0;
    flush_i       = 1'b0;
    #1;
    check_eq("flush_rv_empty", {31'd0, if_valid_o}, 32'd0);
    check_eq("flush_rv_req", {31'd0, imem_req_o}, 32'd1);
    if_ready_i = 1'b1;

    // Slow memory
    fetch(32'h80, 32'hCAFE_F00D, 4, 5);
    #1;
    check_eq("slow_valid", {31'd0, if_valid_o}, 32'd1);
    check_eq("slow_pc", if_pc_o, 32'h80);
    check_eq("slow_instr", if_instr_o, 32'hCAFE_F00D);
    step();
    #1 check_eq("slow_one_push", {31'd0, if_valid_o}, 32'd0);

    // Misaligned pc
    if_ready_i = 1'b0;
    pc_i       = 32'h6;
`ifdef IFETCH_MISALIGN_TRAP_EN
    #1;
    check_eq("mis_no_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("mis_hold", {31'd0, pc_hold_o}, 32'd0);
    step();
    pc_i = 32'h8;
    #1;
    check_eq("mis_valid", {31'd0, if_valid_o}, 32'd1);
    check_eq("mis_pc", if_pc_o, 32'h6);
    check_eq("mis_instr", if_instr_o, 32'h0);
    check_eq("mis_exc", {31'd0, if_exc_o}, 32'd1);
`else
    #1 check_eq("mis_addr", imem_addr_o, 32'h4);
    fetch(32'h6, 32'h3333_3333, 0, 1);
    #1;
    check_eq("mis_valid", {31'd0, if_valid_o}, 32'd1);
    check_eq("mis_pc", if_pc_o, 32'h6);
    check_eq("mis_instr", if_instr_o, 32'h3333_3333);
    check_eq("mis_exc", {31'd0, if_exc_o}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
